cnt_timer_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit down-counting interval timer between two requesters. Each requester asks for the timer with a duration. The block grants exclusive use, loads the counter, counts it to zero, and pulses a per-requester done. It sits between the control logic and the shared counter resource, and it owns every load and decrement of that counter.

---
 rtl/cnt_timer_arb_if.sv | 30 +++
 rtl/cnt_timer_arb.sv | 108 ++++++++++
 tb/tb_cnt_timer_arb.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cnt_timer_arb_if.sv
// Request/grant bundle between two timer clients and cnt_timer_arb.
//   req   : per-requester level request, held until done (or abort)
//   dur0  : duration for requester 0, sampled at grant
//   dur1  : duration for requester 1, sampled at grant
//   grant : one-hot (or zero) owner of the shared counter
//   done  : one-cycle completion pulse to the owner
//   busy  : arbiter not idle
//   value : current counter value
// master modport faces the requesters, slave modport faces the arbiter.
interface cnt_timer_arb_if #(
   parameter int unsigned WIDTH = 8
);
   logic [1:0]       req;
   logic [WIDTH-1:0] dur0;
   logic [WIDTH-1:0] dur1;
   logic [1:0]       grant;
   logic [1:0]       done;
   logic             busy;
   logic [WIDTH-1:0] value;

   modport master (
      output req, dur0, dur1,
      input  grant, done, busy, value
   );

   modport slave (
      input  req, dur0, dur1,
      output grant, done, busy, value
   );
endinterface

// File: rtl/cnt_timer_arb.sv
// Round-robin arbiter sharing one WIDTH-bit down-counting interval timer
// between two requesters. The winner's duration is loaded at grant, the
// counter is decremented to zero, and a one-cycle done pulse is returned.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : cnt_timer_arb_if.slave (req, dur0, dur1 in; grant, done,
//           busy, value out). All outputs are registered.
// Optional feature: define CNT_TIMER_ARB_ABORT_EN so that the owner
// dropping req during RUN aborts the count without a done pulse.
module cnt_timer_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   cnt_timer_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_n;
   logic [1:0]       grant_q, grant_n;
   logic [1:0]       done_q, done_n;
   logic [WIDTH-1:0] value_q, value_n;
   logic             last_q, last_n;
   logic             winner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         value_q <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         done_q  <= done_n;
         value_q <= value_n;
         last_q  <= last_n;
      end
   end

   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      done_n  = '0;
      value_n = value_q;
      last_n  = last_q;
      winner  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               // On a tie the requester that did not own the counter last wins.
               if (bus.req == 2'b11) winner = ~last_q;
               else                  winner = bus.req[1];
               grant_n = winner ? 2'b10 : 2'b01;
               value_n = winner ? bus.dur1 : bus.dur0;
               last_n  = winner;
               if (value_n != '0) begin
                  state_n = RUN;
               end else begin
                  // Zero duration: grant and done rise together.
                  state_n = DONE;
                  done_n  = grant_n;
               end
            end
         end
         RUN: begin
            if (value_q != '0) value_n = value_q - WIDTH'(1);
            if (value_q <= WIDTH'(1)) begin
               state_n = DONE;
               done_n  = grant_q;
            end
`ifdef CNT_TIMER_ARB_ABORT_EN
            // Owner withdrew: release immediately, keep last so the other
            // requester wins the next tie.
            if ((bus.req & grant_q) == 2'b00) begin
               state_n = IDLE;
               grant_n = '0;
               value_n = '0;
               done_n  = '0;
            end
`endif
         end
         DONE: begin
            state_n = IDLE;
            grant_n = '0;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            value_n = '0;
         end
      endcase
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.value = value_q;

endmodule

// File: tb/tb_cnt_timer_arb.sv
// Directed bench for cnt_timer_arb: reset, single request, dur change
// mid-run, zero duration, contention fairness, abort (both builds),
// maximum duration and asynchronous reset mid-run.
module tb_cnt_timer_arb;

   logic clk;
   logic reset;
   int unsigned errors;
   int unsigned checks;

   cnt_timer_arb_if #(.WIDTH(8)) bus_if ();

   cnt_timer_arb #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] g, input logic [1:0] d,
                             input logic b, input logic [7:0] v);
      check({tag, ".grant"}, 32'(bus_if.grant), 32'(g));
      check({tag, ".done"},  32'(bus_if.done),  32'(d));
      check({tag, ".busy"},  32'(bus_if.busy),  32'(b));
      check({tag, ".value"}, 32'(bus_if.value), 32'(v));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b0;
      bus_if.req  = 2'b00;
      bus_if.dur0 = 8'd0;
      bus_if.dur1 = 8'd0;

      // Reset state
      #12;
      expect_out("reset", 2'b00, 2'b00, 1'b0, 8'd0);
      reset = 1'b1;
      tick();
      expect_out("idle_noreq", 2'b00, 2'b00, 1'b0, 8'd0);

      // Single requester, dur0=5; dur change mid-run must be ignored
      bus_if.req  = 2'b01;
      bus_if.dur0 = 8'd5;
      tick();
      expect_out("single.grant", 2'b01, 2'b00, 1'b1, 8'd5);
      bus_if.dur0 = 8'd9;
      for (int i = 4; i >= 1; i--) begin
         tick();
         expect_out("single.run", 2'b01, 2'b00, 1'b1, 8'(i));
      end
      tick();
      expect_out("single.done", 2'b01, 2'b01, 1'b1, 8'd0);
      bus_if.req = 2'b00;
      tick();
      expect_out("single.idle", 2'b00, 2'b00, 1'b0, 8'd0);

      // Zero duration on requester 1
      bus_if.req  = 2'b10;
      bus_if.dur1 = 8'd0;
      tick();
      expect_out("zero.grant_done", 2'b10, 2'b10, 1'b1, 8'd0);
      bus_if.req = 2'b00;
      tick();
      expect_out("zero.idle", 2'b00, 2'b00, 1'b0, 8'd0);

      // Contention: last owner was 1, so grants go 01,10,01,10
      bus_if.req  = 2'b11;
      bus_if.dur0 = 8'd3;
      bus_if.dur1 = 8'd3;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] own;
         own = (k % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         expect_out("rr.grant", own, 2'b00, 1'b1, 8'd3);
         tick();
         check("rr.v2", 32'(bus_if.value), 32'd2);
         tick();
         check("rr.v1", 32'(bus_if.value), 32'd1);
         tick();
         expect_out("rr.done", own, own, 1'b1, 8'd0);
         if (k == 3) bus_if.req = 2'b00;
         tick();
         expect_out("rr.gap", 2'b00, 2'b00, 1'b0, 8'd0);
      end

      // Abort: drop req0 when value reaches 2
      bus_if.req  = 2'b01;
      bus_if.dur0 = 8'd6;
      tick();
      expect_out("abort.grant", 2'b01, 2'b00, 1'b1, 8'd6);
      for (int i = 5; i >= 2; i--) begin
         tick();
         check("abort.run", 32'(bus_if.value), 32'(i));
      end
      bus_if.req = 2'b00;
`ifdef CNT_TIMER_ARB_ABORT_EN
      tick();
      expect_out("abort.idle", 2'b00, 2'b00, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("abort.quiet", 2'b00, 2'b00, 1'b0, 8'd0);
      end
`else
      tick();
      expect_out("noabort.v1", 2'b01, 2'b00, 1'b1, 8'd1);
      tick();
      expect_out("noabort.done", 2'b01, 2'b01, 1'b1, 8'd0);
      tick();
      expect_out("noabort.idle", 2'b00, 2'b00, 1'b0, 8'd0);
`endif

      // Maximum duration: 255 RUN cycles, no wrap, then done
      bus_if.req  = 2'b01;
      bus_if.dur0 = 8'd255;
      tick();
      expect_out("max.grant", 2'b01, 2'b00, 1'b1, 8'd255);
      for (int i = 1; i <= 255; i++) begin
         tick();
         check("max.value", 32'(bus_if.value), 32'(255 - i));
         check("max.done", 32'(bus_if.done), (i == 255) ? 32'd1 : 32'd0);
      end
      bus_if.req = 2'b00;
      tick();
      expect_out("max.idle", 2'b00, 2'b00, 1'b0, 8'd0);

      // Asynchronous reset mid-run at value 6
      bus_if.req  = 2'b01;
      bus_if.dur0 = 8'd10;
      tick();
      expect_out("rst.grant", 2'b01, 2'b00, 1'b1, 8'd10);
      for (int i = 9; i >= 6; i--) begin
         tick();
         check("rst.run", 32'(bus_if.value), 32'(i));
      end
      #2;
      reset = 1'b0;
      #1;
      expect_out("rst.async", 2'b00, 2'b00, 1'b0, 8'd0);
      reset = 1'b1;
      tick();
      expect_out("rst.regrant", 2'b01, 2'b00, 1'b1, 8'd10);
      bus_if.req = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
